// File: rtl/mem_pkg.sv
// Shared data-memory types and helpers: store/load byte masks and load extension.
// The data memory read path uses load_extend from here so forwarding matches it bit for bit.
package mem_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_t;

  typedef struct packed {
    logic [29:0]       waddr;
    logic [1:0]        off;
    logic [1:0]        size;
    logic [DATA_W-1:0] data;
    logic [3:0]        mask;
  } stb_entry_t;

  // Misaligned accesses get an empty mask so they never match anything.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = off[0] ? 4'b0000 : (4'b0011 << off);
      SZ_WORD: m = (off == 2'b00) ? 4'b1111 : 4'b0000;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                     input logic [1:0]        size,
                                                     input logic [1:0]        off,
                                                     input logic              uns);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: r = off[0] ? {DATA_W{1'b1}} : (uns ? {16'h0000, h} : {{16{h[15]}}, h});
      SZ_WORD: r = (off == 2'b00) ? word : {DATA_W{1'b1}};
      default: r = {DATA_W{1'b1}};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stb_fwd_lookup.sv
// One load port probed against the store buffer: per-byte youngest-match forwarding,
// full-cover hit or partial-overlap conflict.
module stb_fwd_lookup
  import mem_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  stb_entry_t [DEPTH-1:0] entries,
  input  logic [PTR_W-1:0]       head,
  input  logic [PTR_W:0]         count,
  input  logic                   ld_valid,
  input  logic [31:0]            ld_addr,
  input  logic [1:0]             ld_size,
  input  logic                   ld_unsigned,
  output logic                   fwd_hit,
  output logic [DATA_W-1:0]      fwd_data,
  output logic                   ld_conflict
);

  localparam int CNT_W = PTR_W + 1;

  logic [3:0]        ld_mask_s;
  logic [3:0]        covered_s;
  logic [3:0]        need_s;
  logic [DATA_W-1:0] word_s;

  assign ld_mask_s = byte_mask(ld_size, ld_addr[1:0]);

  // Walk oldest to youngest; a later match overwrites the byte, so the youngest wins.
  always_comb begin
    logic [PTR_W-1:0]  idx_v;
    logic              live_v;
    logic              sel_v;
    logic [DATA_W-1:0] aligned_v;
    covered_s = 4'b0000;
    word_s    = {DATA_W{1'b0}};
    idx_v     = {PTR_W{1'b0}};
    live_v    = 1'b0;
    sel_v     = 1'b0;
    aligned_v = {DATA_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      idx_v     = head + PTR_W'(i);
      live_v    = (CNT_W'(i) < count) && (entries[idx_v].waddr == ld_addr[31:2]);
      aligned_v = entries[idx_v].data << {entries[idx_v].off, 3'b000};
      for (int b = 0; b < 4; b++) begin
        sel_v            = live_v & entries[idx_v].mask[b];
        covered_s[b]     = covered_s[b] | sel_v;
        word_s[8*b +: 8] = sel_v ? aligned_v[8*b +: 8] : word_s[8*b +: 8];
      end
    end
  end

  assign need_s      = covered_s & ld_mask_s;
  assign fwd_hit     = ld_valid && (ld_mask_s != 4'b0000) && (need_s == ld_mask_s);
  assign ld_conflict = ld_valid && (need_s != 4'b0000) && !fwd_hit;
  assign fwd_data    = fwd_hit ? load_extend(word_s, ld_size, ld_addr[1:0], ld_unsigned)
                               : {DATA_W{1'b1}};

endmodule

// File: rtl/store_commit_buffer.sv
// Committed-store FIFO: accepts stores from ROB commit, drains oldest-first to data
// memory and forwards buffered bytes to load ports.
module store_commit_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int ENQ_WIDTH    = 2,
  parameter int NUM_ST_PORTS = 1,
  parameter int NUM_LD_PORTS = 2,
  parameter int DATA_WIDTH   = DATA_W
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [ENQ_WIDTH-1:0]                   enq_valid,
  input  logic [ENQ_WIDTH-1:0][31:0]             enq_addr,
  input  logic [ENQ_WIDTH-1:0][DATA_WIDTH-1:0]   enq_data,
  input  logic [ENQ_WIDTH-1:0][1:0]              enq_size,
  output logic                                   enq_ready,
  input  logic                                   drain_en,
  output logic [NUM_ST_PORTS-1:0]                mem_write_en,
  output logic [NUM_ST_PORTS-1:0][31:0]          mem_write_addr,
  output logic [NUM_ST_PORTS-1:0][DATA_WIDTH-1:0] mem_write_data,
  output logic [NUM_ST_PORTS-1:0][1:0]           mem_write_size,
  input  logic [NUM_LD_PORTS-1:0]                ld_valid,
  input  logic [NUM_LD_PORTS-1:0][31:0]          ld_addr,
  input  logic [NUM_LD_PORTS-1:0][1:0]           ld_size,
  input  logic [NUM_LD_PORTS-1:0]                ld_unsigned,
  output logic [NUM_LD_PORTS-1:0]                fwd_hit,
  output logic [NUM_LD_PORTS-1:0][DATA_WIDTH-1:0] fwd_data,
  output logic [NUM_LD_PORTS-1:0]                ld_conflict,
  output logic                                   empty,
  output logic [$clog2(DEPTH):0]                 count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  stb_entry_t [DEPTH-1:0]              entries_r;
  logic [PTR_W-1:0]                    head_r;
  logic [PTR_W-1:0]                    tail_r;
  logic [CNT_W-1:0]                    count_r;
  logic                                enq_ready_r;
  logic                                empty_r;
  logic [CNT_W-1:0]                    enq_cnt_s;
  logic [CNT_W-1:0]                    drain_cnt_s;
  logic [CNT_W-1:0]                    count_next_s;
  logic [ENQ_WIDTH-1:0]                accept_s;
  logic [ENQ_WIDTH-1:0][PTR_W-1:0]     lane_pos_s;

  // Accepted lanes pack into consecutive slots from tail, so a lane-0 gap is absorbed.
  always_comb begin
    enq_cnt_s  = {CNT_W{1'b0}};
    accept_s   = {ENQ_WIDTH{1'b0}};
    lane_pos_s = {(ENQ_WIDTH*PTR_W){1'b0}};
    for (int l = 0; l < ENQ_WIDTH; l++) begin
      accept_s[l]   = enq_valid[l] & enq_ready_r;
      lane_pos_s[l] = tail_r + enq_cnt_s[PTR_W-1:0];
      enq_cnt_s     = enq_cnt_s + CNT_W'(accept_s[l]);
    end
  end

  // Drain ports present head+p whenever that entry is occupied.
  always_comb begin
    logic [PTR_W-1:0] idx_v;
    logic             live_v;
    drain_cnt_s    = {CNT_W{1'b0}};
    mem_write_en   = {NUM_ST_PORTS{1'b0}};
    mem_write_addr = {(NUM_ST_PORTS*32){1'b0}};
    mem_write_data = {(NUM_ST_PORTS*DATA_WIDTH){1'b0}};
    mem_write_size = {(NUM_ST_PORTS*2){1'b0}};
    idx_v          = {PTR_W{1'b0}};
    live_v         = 1'b0;
    for (int p = 0; p < NUM_ST_PORTS; p++) begin
      idx_v             = head_r + PTR_W'(p);
      live_v            = count_r > CNT_W'(p);
      mem_write_en[p]   = drain_en & live_v;
      mem_write_addr[p] = live_v ? {entries_r[idx_v].waddr, entries_r[idx_v].off} : 32'h0000_0000;
      mem_write_data[p] = live_v ? entries_r[idx_v].data : {DATA_WIDTH{1'b0}};
      mem_write_size[p] = live_v ? entries_r[idx_v].size : 2'b00;
      drain_cnt_s       = drain_cnt_s + CNT_W'(mem_write_en[p]);
    end
  end

  assign count_next_s = count_r + enq_cnt_s - drain_cnt_s;

  // Pointer/occupancy state; ready and empty are registered from the next count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r      <= {PTR_W{1'b0}};
      tail_r      <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      enq_ready_r <= 1'b1;
      empty_r     <= 1'b1;
    end else begin
      head_r      <= head_r + drain_cnt_s[PTR_W-1:0];
      tail_r      <= tail_r + enq_cnt_s[PTR_W-1:0];
      count_r     <= count_next_s;
      enq_ready_r <= (CNT_W'(DEPTH) - count_next_s) >= CNT_W'(ENQ_WIDTH);
      empty_r     <= count_next_s == {CNT_W{1'b0}};
    end
  end

  // Entry storage; the mask is fixed at enqueue so lookups never recompute it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries_r <= '0;
    end else begin
      for (int l = 0; l < ENQ_WIDTH; l++) begin
        if (accept_s[l]) begin
          entries_r[lane_pos_s[l]] <= '{waddr: enq_addr[l][31:2],
                                        off:   enq_addr[l][1:0],
                                        size:  enq_size[l],
                                        data:  enq_data[l],
                                        mask:  byte_mask(enq_size[l], enq_addr[l][1:0])};
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_LD_PORTS; g++) begin : g_ld
    stb_fwd_lookup #(.DEPTH(DEPTH)) u_lookup (
      .entries     (entries_r),
      .head        (head_r),
      .count       (count_r),
      .ld_valid    (ld_valid[g]),
      .ld_addr     (ld_addr[g]),
      .ld_size     (ld_size[g]),
      .ld_unsigned (ld_unsigned[g]),
      .fwd_hit     (fwd_hit[g]),
      .fwd_data    (fwd_data[g]),
      .ld_conflict (ld_conflict[g])
    );
  end

  assign enq_ready = enq_ready_r;
  assign empty     = empty_r;
  assign count     = count_r;

endmodule

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
- Initiator side of the data memory store/load interface.
- Holds committed stores from the ROB in a FIFO and drains them oldest-first onto the data memory write port(s), one entry per port per cycle.
- Answers load-port lookups with store-to-load forwarding, or a conflict stall, so loads never read stale memory while older committed stores are still buffered.
- Sits between ROB commit / LSU and the data memory.

Parameters:
- DEPTH, 8, buffer entries; power of two, at least 4.
- ENQ_WIDTH, 2, committed stores accepted per cycle; lane 0 is older than lane 1.
- NUM_ST_PORTS, 1, drain ports to data memory.
- NUM_LD_PORTS, 2, load lookup ports.
- DATA_WIDTH, 32, data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- enq_valid  in  [ENQ_WIDTH]  committed store present on lane.
- enq_addr  in  32 x ENQ_WIDTH  byte address.
- enq_data  in  DATA_WIDTH x ENQ_WIDTH  store data, right-aligned.
- enq_size  in  2 x ENQ_WIDTH  00 byte, 01 half, 10 word.
- enq_ready  out  1  at least ENQ_WIDTH free entries.
- drain_en  in  1  memory accepts stores this cycle.
- mem_write_en  out  [NUM_ST_PORTS]  to data memory write_en.
- mem_write_addr / mem_write_data / mem_write_size  out  32 / DATA_WIDTH / 2, each x NUM_ST_PORTS.
- ld_valid  in  [NUM_LD_PORTS]  load probing this cycle.
- ld_addr  in  32 x NUM_LD_PORTS.
- ld_size  in  2 x NUM_LD_PORTS.
- ld_unsigned  in  [NUM_LD_PORTS].
- fwd_hit  out  [NUM_LD_PORTS]  all load bytes supplied by buffer.
- fwd_data  out  DATA_WIDTH x NUM_LD_PORTS  extended load result, valid when fwd_hit.
- ld_conflict  out  [NUM_LD_PORTS]  partial overlap; LSU must replay.
- empty  out  1  count == 0; used by FENCE.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Entry fields: word address (addr[31:2]), byte offset, size, data, 4-bit byte mask.
- Byte mask is computed at enqueue:
  - SB: 1<<off.
  - SH with off[0]==0: 3<<off.
  - SW with off==0: 4'hF.
  - Anything else (misaligned): 0. The entry is still enqueued and drained unmodified, but never forwards; data memory drops it.
- Circular FIFO: head_ptr, tail_ptr, count registers; pointers wrap modulo DEPTH.
- Reset (rst_n low, asynchronous): pointers = 0, count = 0, all entry masks = 0.
- All outputs after reset: enq_ready = 1, empty = 1, mem_write_en = 0, fwd_hit = 0, ld_conflict = 0, fwd_data = all-ones.
- Reset mid-operation discards every buffered store; no write is issued in the reset cycle.
- Enqueue:
  - enq_ready = (DEPTH - count) >= ENQ_WIDTH, computed from registered count only. It is never combinationally dependent on drain.
  - Valid lanes are written in lane order to tail, tail+1.
  - A gap (lane 1 valid, lane 0 not) is legal and packs into tail.
  - enq_valid while !enq_ready is a protocol error; the bench asserts on it and RTL ignores those lanes.
- Drain:
  - Port p presents entry head+p combinationally whenever count > p.
  - mem_write_en[p] = drain_en && (count > p).
  - Entries pop at posedge in the same cycle.
- count_next = count + enqueued - drained; simultaneous enqueue and drain are fully supported.
- Write timing vs. loads:
  - Data memory writes at the same posedge the entry pops.
  - A drained entry remains visible to forwarding during its drain cycle.
  - From the next cycle the memory holds the value.
- Forwarding lookup (combinational, per load port):
  - Compute the load mask with the same rule as the store mask; a misaligned load gives mask 0, hence no hit and no conflict.
  - Per byte, select the youngest valid entry with matching word address and that mask bit set. Youngest means closest to tail, counting only entries in the occupied range.
  - Covered = OR of the selected bytes' coverage.
  - fwd_hit = ld_valid && load_mask != 0 && (covered & load_mask) == load_mask.
  - ld_conflict = ld_valid && (covered & load_mask) != 0 && !fwd_hit.
  - fwd_data: the assembled word is byte-selected and sign- or zero-extended exactly as data memory does: LB/LBU on the offset byte, LH/LHU on the offset half, LW the full word. Otherwise all-ones.
- Stores enqueued this cycle are not visible to loads until the next cycle.

Decomposition:
- Shared package mem_pkg:
  - mem_size_t (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10).
  - Function byte_mask(size, off).
  - Function load_extend(word, size, off, unsigned).
  - The data memory read path adopts load_extend from the same package.
- One sub-module, stb_fwd_lookup: one load port against the entry array. It is instantiated NUM_LD_PORTS times.

Test Plan:
- Reset, then enqueue SW 0x100 = 0xDEADBEEF with drain_en = 0 -> count = 1, empty = 0, mem_write_en = 0. Assert drain_en -> one cycle with mem_write_en = 1, addr 0x100, data 0xDEADBEEF, size 10; next cycle count = 0, empty = 1.
- Buffer SW 0x200 = 0x11223344, then SB 0x202 = 0xAA. Load LW 0x200 -> fwd_hit = 1, fwd_data = 0x11AA3344. LB 0x202 signed -> 0xFFFFFFAA. LBU -> 0x000000AA.
- Buffer SB 0x300 = 0x55 only. LW 0x300 -> ld_conflict = 1, fwd_hit = 0. LW 0x304 -> both 0 (memory path).
- Fill to DEPTH-1 -> enq_ready = 0. Drain one -> enq_ready = 1 next cycle. Enqueue 2 while draining 1 over 3*DEPTH stores -> pointer wrap; drain order equals commit order, lane 0 before lane 1.
- SH 0x401 (misaligned) buffered, then LH 0x400 -> no hit and no conflict; the entry still drains with size 01, addr 0x401.
- Pull rst_n low mid-drain with count = 5 -> immediately count = 0, mem_write_en = 0, empty = 1.
